// File: rtl/rr_mux_arbiter_if.sv
// Requester/consumer bundle for rr_mux_arbiter: requests, flattened data, mux
// select, accept strobes and the registered valid/ready output stage.
interface rr_mux_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 4
);
    logic [NUM_REQ-1:0]        req_i;
    logic [NUM_REQ*DATA_W-1:0] data_i;
    logic [NUM_REQ-1:0]        sel_o;
    logic [NUM_REQ-1:0]        gnt_o;
    logic                      valid_o;
    logic [DATA_W-1:0]         data_o;
    logic                      ready_i;

    modport master (
        output req_i, data_i, ready_i,
        input  sel_o, gnt_o, valid_o, data_o
    );

    modport slave (
        input  req_i, data_i, ready_i,
        output sel_o, gnt_o, valid_o, data_o
    );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving a one-hot shared mux into a registered valid/ready
// output stage. Define RR_ARB_BURST_EN to allow MAX_BURST back-to-back grants.
module rr_mux_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 4,
    parameter int MAX_BURST = 4
) (
    input logic             clk,
    input logic             reset,
    rr_mux_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || MAX_BURST < 1) begin : g_bad_cfg
        $error("rr_mux_arbiter: NUM_REQ must be >= 2 and MAX_BURST >= 1");
    end

    logic [PTR_W-1:0]   r_ptr;
    logic               r_valid;
    logic [DATA_W-1:0]  r_data;

    logic [NUM_REQ-1:0] w_sel;
    logic [PTR_W-1:0]   w_win;
    logic               w_found;
    logic               w_load;
    logic               w_grant;
    logic [DATA_W-1:0]  w_mux;
    logic [PTR_W-1:0]   w_ptr_nxt;

    // Search starts just after the last served requester and wraps.
    always_comb begin
        w_sel   = '0;
        w_win   = '0;
        w_found = 1'b0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            logic [PTR_W-1:0] w_idx;
            w_idx = PTR_W'((32'(r_ptr) + off) % NUM_REQ);
            if (!w_found && bus.req_i[w_idx]) begin
                w_found      = 1'b1;
                w_sel[w_idx] = 1'b1;
                w_win        = w_idx;
            end
        end
    end

    always_comb begin
        w_mux = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_mux = w_mux | (bus.data_i[k*DATA_W +: DATA_W] & {DATA_W{w_sel[k]}});
        end
    end

    assign w_load  = ~r_valid | bus.ready_i;
    assign w_grant = w_found & w_load;

`ifdef RR_ARB_BURST_EN
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    logic [CNT_W-1:0] r_cnt;
    logic [PTR_W-1:0] r_last;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_upd;

    // Parking ptr one below the winner keeps it first in line for the next search.
    always_comb begin
        w_cnt_nxt = (r_cnt != '0 && w_win == r_last) ? r_cnt + 1'b1 : CNT_W'(1);
        if (int'(w_cnt_nxt) < MAX_BURST) begin
            w_cnt_upd = w_cnt_nxt;
            w_ptr_nxt = (w_win == '0) ? PTR_W'(NUM_REQ - 1) : w_win - 1'b1;
        end else begin
            w_cnt_upd = '0;
            w_ptr_nxt = w_win;
        end
    end
`else
    assign w_ptr_nxt = w_win;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ptr   <= PTR_W'(NUM_REQ - 1);
`ifdef RR_ARB_BURST_EN
            r_cnt   <= '0;
            r_last  <= '0;
`endif
        end else if (w_load) begin
            r_valid <= |bus.req_i;
            if (w_grant) begin
                r_data <= w_mux;
                r_ptr  <= w_ptr_nxt;
`ifdef RR_ARB_BURST_EN
                r_cnt  <= w_cnt_upd;
                r_last <= w_win;
`endif
            end
        end
    end

    assign bus.sel_o   = reset ? '0 : w_sel;
    assign bus.gnt_o   = bus.sel_o & {NUM_REQ{w_load}};
    assign bus.valid_o = r_valid;
    assign bus.data_o  = r_data;
endmodule
